// File: rtl/maxpool_2x2_stream_if.sv
// Valid/ready stream bundle for the 2x2 max-pool stage: pixel input side and pooled output side.
// master = upstream/downstream environment, slave = the pooling block.
interface maxpool_2x2_stream_if #(
  parameter int unsigned DATW = 10
) ();
  logic            in_valid;
  logic            in_ready;
  logic [DATW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DATW-1:0] out_data;
  logic            out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a raster pixel stream, using one row of partial maxima.
// Trailing odd column/row are accepted and dropped.
module maxpool_2x2_stream #(
  parameter int unsigned DATW = 10,
  parameter int unsigned FMW  = 8,
  parameter int unsigned FMH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  maxpool_2x2_stream_if.slave   bus,
  output logic                  done
);

  localparam int unsigned CW       = (FMW > 1) ? $clog2(FMW) : 1;
  localparam int unsigned RW       = (FMH > 1) ? $clog2(FMH) : 1;
  localparam int unsigned PW       = FMW / 2;
  localparam int unsigned BW       = (PW > 1) ? $clog2(PW) : 1;
  localparam int unsigned LAST_COL = 2 * PW - 1;
  localparam int unsigned LAST_ROW = 2 * (FMH / 2) - 1;

  typedef enum logic [1:0] {
    EVEN_ROW,
    ODD_ROW,
    DROP
  } state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [DATW-1:0] hmax;
  logic [DATW-1:0] rbuf [PW];

  logic            out_valid_q;
  logic [DATW-1:0] out_data_q;
  logic            out_last_q;

  logic            beat_c;
  logic            col_end_c;
  logic            row_end_c;
  logic [BW-1:0]   pidx_c;
  logic [DATW-1:0] pair_max_c;
  logic [DATW-1:0] pool_c;

  // Stall input whenever an untaken result sits in the output register.
  assign bus.in_ready  = !rst && !(out_valid_q && !bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  assign beat_c     = bus.in_valid && bus.in_ready;
  assign col_end_c  = (col == CW'(FMW - 1));
  assign row_end_c  = (row == RW'(FMH - 1));
  assign pidx_c     = BW'(col >> 1);
  assign pair_max_c = (bus.in_data > hmax) ? bus.in_data : hmax;
  assign pool_c     = (rbuf[pidx_c] > pair_max_c) ? rbuf[pidx_c] : pair_max_c;

  // Raster counters, row-parity state, output register and frame-done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EVEN_ROW;
      col         <= '0;
      row         <= '0;
      hmax        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= beat_c && row_end_c && col_end_c;

      // A new result wins over a same-cycle transfer, so no bubble is inserted.
      if (beat_c && (state == ODD_ROW) && col[0]) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pool_c;
        out_last_q  <= (row == RW'(LAST_ROW)) && (col == CW'(LAST_COL));
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end

      if (beat_c) begin
        if (!col[0]) begin
          hmax <= bus.in_data;
        end
        if (col_end_c) begin
          col <= '0;
          if (row_end_c) begin
            row   <= '0;
            state <= EVEN_ROW;
          end else begin
            row <= row + RW'(1);
            case (state)
              EVEN_ROW: state <= ODD_ROW;
              ODD_ROW:  state <= (row == RW'(FMH - 2)) ? DROP : EVEN_ROW;
              default:  state <= EVEN_ROW;
            endcase
          end
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Partial maxima of the even row; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (beat_c && (state == EVEN_ROW) && col[0]) begin
      rbuf[pidx_c] <= pair_max_c;
    end
  end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Bench for maxpool_2x2_stream: 4x4 instance with a scoreboard on the output stream, plus a 3x3 instance
// exercising the dropped trailing row and column.
module tb_maxpool_2x2_stream;

  localparam int unsigned DATW = 10;

  typedef struct packed {
    logic [DATW-1:0] a;
    logic [DATW-1:0] b;
    logic [DATW-1:0] c;
    logic [DATW-1:0] d;
    logic [DATW-1:0] mx;
  } win_t;

  typedef struct packed {
    logic [DATW-1:0] data;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic done4;
  logic done3;

  always #5 clk = ~clk;

  maxpool_2x2_stream_if #(.DATW(DATW)) bus4 ();
  maxpool_2x2_stream_if #(.DATW(DATW)) bus3 ();

  maxpool_2x2_stream #(.DATW(DATW), .FMW(4), .FMH(4)) u_dut4 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus4),
    .done (done4)
  );

  maxpool_2x2_stream #(.DATW(DATW), .FMW(3), .FMH(3)) u_dut3 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus3),
    .done (done3)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   n_done4 = 0;
  int   n_last4 = 0;

  win_t            win_tab [8];
  logic [DATW-1:0] frm3 [2][9];
  logic [DATW-1:0] exp3 [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [DATW-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  function automatic logic [DATW-1:0] win_px(input win_t w, input int k);
    case (k)
      0:       return w.a;
      1:       return w.b;
      2:       return w.c;
      default: return w.d;
    endcase
  endfunction

  // One input beat on the 4x4 instance; returns #1 after the accepting edge.
  task automatic send4(input logic [DATW-1:0] px);
    int budget;
    budget = 0;
    bus4.in_valid = 1'b1;
    bus4.in_data  = px;
    @(negedge clk);
    while (!bus4.in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!bus4.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL in_ready_timeout: got 0, want 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle4(input int n);
    bus4.in_valid = 1'b0;
    bus4.in_data  = 10'h3ff;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output transfer of the 4x4 instance is matched against the queue.
  always @(negedge clk) begin
    if (done4) n_done4++;
    if (!rst && bus4.out_valid && bus4.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %0d, want no output", bus4.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_out_data", 32'(bus4.out_data), 32'(mon_e.data));
        check("sb_out_last", 32'(bus4.out_last), 32'(mon_e.last));
        if (bus4.out_last) n_last4++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int l0;

    // Windows: top row a,b then bottom row c,d; mx is the hand-computed unsigned max.
    win_tab[0] = {10'd1023, 10'd0,    10'd0,    10'd0,    10'd1023};
    win_tab[1] = {10'd0,    10'd1023, 10'd0,    10'd0,    10'd1023};
    win_tab[2] = {10'd0,    10'd0,    10'd1023, 10'd0,    10'd1023};
    win_tab[3] = {10'd0,    10'd0,    10'd0,    10'd1023, 10'd1023};
    win_tab[4] = {10'd512,  10'd511,  10'd1,    10'd1022, 10'd1022};
    win_tab[5] = {10'd3,    10'd9,    10'd9,    10'd2,    10'd9};
    win_tab[6] = {10'd0,    10'd0,    10'd0,    10'd0,    10'd0};
    win_tab[7] = {10'd700,  10'd800,  10'd900,  10'd600,  10'd900};

    frm3[0] = '{10'd9, 10'd1, 10'd4, 10'd2, 10'd8, 10'd3, 10'd7, 10'd6, 10'd5};
    frm3[1] = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9};
    exp3[0] = 10'd9;
    exp3[1] = 10'd5;

    rst            = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in_data   = '0;
    bus4.out_ready = 1'b1;
    bus3.in_valid  = 1'b0;
    bus3.in_data   = '0;
    bus3.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_out_data",  32'(bus4.out_data),  32'd0);
    check("rst_out_last",  32'(bus4.out_last),  32'd0);
    check("rst_done",      32'(done4),          32'd0);
    check("rst_in_ready",  32'(bus4.in_ready),  32'd0);
    check("rst_in_ready3", 32'(bus3.in_ready),  32'd0);
    rst = 1'b0;

    // 4x4 frame 0..15 with per-beat output timing.
    push_exp(10'd5, 1'b0);
    push_exp(10'd7, 1'b0);
    push_exp(10'd13, 1'b0);
    push_exp(10'd15, 1'b1);
    d0 = n_done4;
    for (int i = 0; i < 16; i++) begin
      send4(10'(i));
      check("ramp_out_valid", 32'(bus4.out_valid), 32'(i == 5 || i == 7 || i == 13 || i == 15));
      check("ramp_done", 32'(done4), 32'(i == 15));
    end
    idle4(2);
    check("ramp_done_count", 32'(n_done4 - d0), 32'd1);
    check("ramp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Output stall for 5 cycles after the first result.
    push_exp(10'd5, 1'b0);
    push_exp(10'd7, 1'b0);
    push_exp(10'd13, 1'b0);
    push_exp(10'd15, 1'b1);
    for (int i = 0; i < 6; i++) send4(10'(i));
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.in_data   = 10'd6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready",  32'(bus4.in_ready),  32'd0);
      check("stall_out_valid", 32'(bus4.out_valid), 32'd1);
      check("stall_out_data",  32'(bus4.out_data),  32'd5);
      @(posedge clk);
      #1;
    end
    bus4.out_ready = 1'b1;
    for (int i = 6; i < 16; i++) send4(10'(i));
    idle4(2);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // Two back-to-back table frames with in_valid held high.
    d0 = n_done4;
    l0 = n_last4;
    for (int w = 0; w < 8; w++) push_exp(win_tab[w].mx, 1'(w % 4 == 3));
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          send4(win_px(win_tab[f * 4 + (r / 2) * 2 + c / 2], (r % 2) * 2 + c % 2));
    idle4(2);
    check("b2b_done_count", 32'(n_done4 - d0), 32'd2);
    check("b2b_last_count", 32'(n_last4 - l0), 32'd2);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset after 6 beats of a frame; the partial frame must vanish.
    d0 = n_done4;
    l0 = n_last4;
    bus4.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send4(10'(i));
    rst = 1'b1;
    bus4.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus4.out_ready = 1'b1;
    check("mid_rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("mid_rst_out_last",  32'(bus4.out_last),  32'd0);
    push_exp(10'd5, 1'b0);
    push_exp(10'd7, 1'b0);
    push_exp(10'd13, 1'b0);
    push_exp(10'd15, 1'b1);
    for (int i = 0; i < 16; i++) send4(10'(i));
    idle4(2);
    check("mid_rst_done_count", 32'(n_done4 - d0), 32'd1);
    check("mid_rst_last_count", 32'(n_last4 - l0), 32'd1);
    check("mid_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3x3 frames: one window each, trailing column and row dropped.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 9; i++) begin
        check("fm3_in_ready", 32'(bus3.in_ready), 32'd1);
        bus3.in_valid = 1'b1;
        bus3.in_data  = frm3[f][i];
        @(posedge clk);
        #1;
        check("fm3_out_valid", 32'(bus3.out_valid), 32'(i == 4));
        if (i == 4) begin
          check("fm3_out_data", 32'(bus3.out_data), 32'(exp3[f]));
          check("fm3_out_last", 32'(bus3.out_last), 32'd1);
        end
        check("fm3_done", 32'(done3), 32'(i == 8));
      end
    end
    bus3.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/maxpool_2x2_stream.md
# maxpool_2x2_stream

Streaming 2×2, stride-2 max-pool stage placed directly downstream of the 3×3 convolution engine. It consumes the convolution's output feature map as a raster-ordered unsigned pixel stream and emits the pooled map as a raster-ordered stream. A one-row buffer of partial maxima is used, so there is no frame storage. Valid/ready handshakes on both sides let it sit between the convolution engine and the next layer.

## Interface
- DATW, 10, pixel width (unsigned), equal to the convolution output width
- FMW, 8, input feature-map width in pixels (≥2)
- FMH, 8, input feature-map height in pixels (≥2)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  DATW  input pixel, raster order, row-major
- out_valid  out  1  pooled pixel valid
- out_ready  in  1  downstream accepts output
- out_data  out  DATW  pooled pixel
- out_last  out  1  marks last pooled pixel of the frame, qualified by out_valid
- done  out  1  one-cycle pulse on frame completion

## Operation
- Beat = cycle with in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Counters: col 0..FMW-1, row 0..FMH-1. Both advance on input beats only. col wraps to 0 and increments row. After the beat at (FMH-1, FMW-1), both clear to 0 and the next frame starts with no idle gap.
- Pool window spans rows {2r, 2r+1} and cols {2c, 2c+1}, for r < FMH/2 and c < FMW/2 (floor).
- Odd FMW: the trailing column is accepted and discarded.
- Odd FMH: the trailing row is accepted and discarded.
- Horizontal pair register hmax:
  - even col: load in_data.
  - odd col: pair max = max(hmax, in_data).
- Row buffer, FMW/2 entries of DATW:
  - even row, odd col (c<FMW/2): write pair max to rbuf[c].
  - odd row, odd col (c<FMW/2): result = max(rbuf[c], pair max) is loaded into the output register, and out_valid is set.
- Comparisons are unsigned. There is no arithmetic other than max, so there is no overflow.
- State machine:
  - EVEN_ROW: fills rbuf. Goes to ODD_ROW at the end of the row.
  - ODD_ROW: emits outputs. At the end of the row it goes to EVEN_ROW, or to DROP if the next row is the odd trailing row FMH-1, or stays at frame end handling below.
  - DROP: consumes the trailing row with no writes. Goes to EVEN_ROW at the end of the row.
  - The frame-end beat returns the machine to EVEN_ROW with counters cleared.
- out_last is set with the output for window (FMH/2-1, FMW/2-1).
- done is a one-cycle pulse in the cycle after the frame's final input beat at (FMH-1, FMW-1). It does not depend on whether the last output has drained.
- Backpressure: in_ready = !rst && !(out_valid && !out_ready). The block stalls all input while the output register holds an untaken pixel, even when the next beat would produce no output.
- out_valid clears on an output transfer unless a new result loads in the same cycle. out_data and out_last stay stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, done=0, in_ready=0 while rst is high. State is EVEN_ROW, col=row=0, hmax=0. rbuf contents don't care.
- Latency: out_valid rises the cycle after the beat of the pixel at the bottom-right of the window (1 cycle).
- Full throughput is one input per cycle when out_ready stays high.
- Simultaneous output transfer and new result: the new result overwrites, out_valid stays 1, and no bubble is inserted.
- Reset mid-frame: the partial frame is discarded with no output and no done. The first beat after reset is pixel (0,0) of a new frame.
- in_data is sampled only on beats. Values while in_valid=0 are ignored.

## Test plan
- FMW=FMH=4, input 0..15 raster, out_ready=1 → outputs 5,7,13,15, one cycle after input beats 5,7,13,15. out_last on 15. done one cycle after beat 15.
- FMW=FMH=3 (conv 3×3 output), input 9,1,4,2,8,3,7,6,5 → single output 9 with out_last=1. The trailing column and row are dropped. done after the 9th beat.
- FMW=FMH=4, out_ready held low for 5 cycles after the first output → out_data=5 is held stable and in_ready=0 during the stall. No data loss; the sequence is 5,7,13,15.
- Pixel values 1023 and 0 mixed (DATW=10), with max at each window position in turn → correct unsigned max and no sign misinterpretation.
- Two back-to-back frames with in_valid held high → frame 2 outputs correct with no gap. done pulses twice, and out_last fires twice.
- rst asserted for 1 cycle after 6 beats of a 4×4 frame → no outputs and no done. A fresh frame 0..15 then yields 5,7,13,15.
